mem_xfer_arbiter: RTL and testbench
===================================

Name: mem_xfer_arbiter

Overview:
Arbitrates between the AXI transfer path and the CSR transfer path for the single memory interface controller. It issues one start at a time and holds it until the controller acknowledges. It then tracks the transaction through chip-select activity and enforces a programmable CS-high gap before the next grant. A watchdog recovers from transfers that never assert chip-select.

Parameters:
TO_WIDTH, 10, width of watchdog counter; timeout fires after 2^TO_WIDTH-1 cycles without cs_n falling.
CSR_FIRST, 1, tie-break when both requests are pending and the last grant was neither (after reset): 1 = CSR wins, 0 = AXI wins.

Ports:
mem_clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
axi_req  input  1  AXI side requests a transfer (level, held until axi_grant_ack)
csr_req  input  1  CSR side requests a transfer (level, held until csr_grant_ack)
axi_grant_ack  output  1  one-cycle pulse: AXI request accepted by controller
csr_grant_ack  output  1  one-cycle pulse: CSR request accepted by controller
axi_start_mem_xfer  output  1  start to controller, AXI path
csr_start_mem_xfer  output  1  start to controller, CSR path
axi_start_mem_xfer_ack  input  1  controller ack for AXI start
csr_start_mem_xfer_ack  input  1  controller ack for CSR start
cs_n  input  1  chip select from controller, active low
cs_gap  input  5  minimum idle cycles between transfers (CSR cs_high)
arb_busy  output  1  high in any state other than IDLE
grant_owner  output  2  00 none, 01 AXI, 10 CSR
xfer_timeout_err  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset values (asynchronous, reset_n low): all outputs 0; state IDLE; last-grant register = none; counters 0.
- Synchronous to mem_clk; all outputs registered.
- States: IDLE, ISSUE, BUSY, GAP.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one request pending: grant it.
  - Both pending: grant the side not granted last (round-robin); if last grant = none, apply CSR_FIRST.
  - Next cycle: enter ISSUE, the chosen start output = 1, grant_owner set.
  - No request: stay in IDLE.
- ISSUE:
  - Start stays high until the matching ack is sampled high. The ack of the other path is ignored.
  - On ack: start = 0 and grant_ack pulse = 1 in the next cycle; enter BUSY; watchdog cleared; seen_low = 0.
  - Once in ISSUE the grant is committed: the requester dropping its req does not cancel it.
- BUSY:
  - cs_n low sets seen_low.
  - Completion = seen_low && cs_n rising (registered cs_n_q = 0, cs_n = 1): enter GAP with gap counter = cs_gap.
  - Watchdog increments each BUSY cycle while seen_low = 0. At all-ones: xfer_timeout_err pulse, enter GAP.
  - cs_n already low on BUSY entry counts as seen_low.
- GAP:
  - Counter decrements each cycle; at 0, enter IDLE and grant_owner = 00.
  - cs_gap = 0: GAP lasts exactly 1 cycle.
  - cs_gap is sampled on GAP entry only; changes mid-gap have no effect.
- Minimum turnaround from completion to the next start = cs_gap + 2 cycles.
- Reset asserted mid-transfer: immediate return to IDLE; start outputs drop asynchronously; no ack pulse.
- arb_busy = (state != IDLE).

Test Plan:
- Only axi_req = 1, ack after 3 cycles, cs_n low 5 cycles, cs_gap = 4 -> axi_start high 3 cycles, single axi_grant_ack pulse, arb_busy drops exactly 5 cycles after cs_n rises.
- axi_req and csr_req both held from reset, CSR_FIRST = 1 -> grant order CSR, AXI, CSR, AXI; grant_owner toggles 10/01.
- Ack arrives in the same cycle start rises -> start high exactly 1 cycle; no double ack; BUSY entered.
- Ack given, cs_n never falls, TO_WIDTH = 4 -> xfer_timeout_err pulses 15 cycles after BUSY entry; IDLE reached after the gap.
- cs_gap = 0, back-to-back AXI requests -> second start rises 2 cycles after the cs_n rising edge.
- reset_n pulsed low during BUSY -> all outputs 0 immediately; a pending csr_req is re-granted from IDLE after release.

Source files
------------

// File: rtl/mem_xfer_arbiter.sv
// mem_xfer_arbiter: grants the single memory controller to the AXI or CSR
// transfer path, holds start until acked, tracks cs_n and spaces transfers.
// Ports: mem_clk/reset_n; axi_req/csr_req in, *_grant_ack pulses out;
// *_start_mem_xfer to controller with *_start_mem_xfer_ack back; cs_n and
// cs_gap in; arb_busy, grant_owner, xfer_timeout_err status out.
module mem_xfer_arbiter #(
  parameter int TO_WIDTH  = 10,
  parameter bit CSR_FIRST = 1'b1
) (
  input  logic       mem_clk,
  input  logic       reset_n,
  input  logic       axi_req,
  input  logic       csr_req,
  output logic       axi_grant_ack,
  output logic       csr_grant_ack,
  output logic       axi_start_mem_xfer,
  output logic       csr_start_mem_xfer,
  input  logic       axi_start_mem_xfer_ack,
  input  logic       csr_start_mem_xfer_ack,
  input  logic       cs_n,
  input  logic [4:0] cs_gap,
  output logic       arb_busy,
  output logic [1:0] grant_owner,
  output logic       xfer_timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    GAP
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_AXI  = 2'b01;
  localparam logic [1:0] OWN_CSR  = 2'b10;

  state_t              state;
  logic [1:0]          last_grant;
  logic [TO_WIDTH-1:0] wd;
  logic [TO_WIDTH-1:0] wd_nxt;
  logic [4:0]          gap_cnt;
  logic                seen_low;
  logic                cs_n_q;
  logic                pick_csr;
  logic                start_ack;
  logic                cs_rise;

  assign wd_nxt  = wd + 1'b1;
  assign cs_rise = seen_low & ~cs_n_q & cs_n;

  // Only the ack belonging to the committed owner counts.
  assign start_ack = (grant_owner == OWN_CSR) ?
                     csr_start_mem_xfer_ack :
                     axi_start_mem_xfer_ack;

  // Round-robin on contention; fixed tie-break before any grant.
  always_comb begin
    pick_csr = csr_req;
    if (axi_req && csr_req) begin
      unique case (1'b1)
        (last_grant == OWN_AXI): pick_csr = 1'b1;
        (last_grant == OWN_CSR): pick_csr = 1'b0;
        default:                 pick_csr = CSR_FIRST;
      endcase
    end
  end

  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      axi_grant_ack      <= 1'b0;
      csr_grant_ack      <= 1'b0;
      axi_start_mem_xfer <= 1'b0;
      csr_start_mem_xfer <= 1'b0;
      arb_busy           <= 1'b0;
      grant_owner        <= OWN_NONE;
      xfer_timeout_err   <= 1'b0;
      last_grant         <= OWN_NONE;
      wd                 <= '0;
      gap_cnt            <= '0;
      seen_low           <= 1'b0;
      cs_n_q             <= 1'b1;
    end else begin
      axi_grant_ack    <= 1'b0;
      csr_grant_ack    <= 1'b0;
      xfer_timeout_err <= 1'b0;
      cs_n_q           <= cs_n;
      unique case (state)
        IDLE: begin
          if (axi_req || csr_req) begin
            state    <= ISSUE;
            arb_busy <= 1'b1;
            if (pick_csr) begin
              csr_start_mem_xfer <= 1'b1;
              grant_owner        <= OWN_CSR;
              last_grant         <= OWN_CSR;
            end else begin
              axi_start_mem_xfer <= 1'b1;
              grant_owner        <= OWN_AXI;
              last_grant         <= OWN_AXI;
            end
          end
        end
        ISSUE: begin
          if (start_ack) begin
            state              <= BUSY;
            axi_start_mem_xfer <= 1'b0;
            csr_start_mem_xfer <= 1'b0;
            axi_grant_ack      <= (grant_owner == OWN_AXI);
            csr_grant_ack      <= (grant_owner == OWN_CSR);
            wd                 <= '0;
            seen_low           <= 1'b0;
          end
        end
        BUSY: begin
          if (!cs_n) begin
            seen_low <= 1'b1;
          end
          if (cs_rise) begin
            state   <= GAP;
            gap_cnt <= cs_gap;
          end else if (!seen_low && cs_n) begin
            // Counts BUSY cycles with no chip-select activity yet.
            if (&wd_nxt) begin
              xfer_timeout_err <= 1'b1;
              state            <= GAP;
              gap_cnt          <= cs_gap;
            end else begin
              wd <= wd_nxt;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 5'd0) begin
            state       <= IDLE;
            arb_busy    <= 1'b0;
            grant_owner <= OWN_NONE;
          end else begin
            gap_cnt <= gap_cnt - 5'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_xfer_arbiter.sv
// tb_mem_xfer_arbiter: randomized transfers against a request-set model,
// with a scoreboard monitor checking grants, start widths and timing.
module tb_mem_xfer_arbiter;

  localparam int TOW    = 4;
  localparam int TO_CYC = (1 << TOW) - 1;

  logic       mem_clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       axi_req = 1'b0;
  logic       csr_req = 1'b0;
  logic       axi_ack = 1'b0;
  logic       csr_ack = 1'b0;
  logic       cs_n    = 1'b1;
  logic [4:0] cs_gap  = 5'd0;
  logic       axi_grant_ack;
  logic       csr_grant_ack;
  logic       axi_start;
  logic       csr_start;
  logic       arb_busy;
  logic [1:0] grant_owner;
  logic       xfer_timeout_err;

  mem_xfer_arbiter #(
    .TO_WIDTH (TOW),
    .CSR_FIRST(1'b1)
  ) dut (
    .mem_clk               (mem_clk),
    .reset_n               (reset_n),
    .axi_req               (axi_req),
    .csr_req               (csr_req),
    .axi_grant_ack         (axi_grant_ack),
    .csr_grant_ack         (csr_grant_ack),
    .axi_start_mem_xfer    (axi_start),
    .csr_start_mem_xfer    (csr_start),
    .axi_start_mem_xfer_ack(axi_ack),
    .csr_start_mem_xfer_ack(csr_ack),
    .cs_n                  (cs_n),
    .cs_gap                (cs_gap),
    .arb_busy              (arb_busy),
    .grant_owner           (grant_owner),
    .xfer_timeout_err      (xfer_timeout_err)
  );

  always #5 mem_clk = ~mem_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge mem_clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Expected grants: side 1 = AXI, 2 = CSR; start width in cycles.
  typedef struct {
    bit to;
    int cyc_to;
    int cyc_end;
  } end_t;

  int   side_q[$];
  int   len_q[$];
  end_t end_q[$];

  bit mon_en  = 1'b0;
  bit busy_q  = 1'b0;
  bit to_seen = 1'b0;
  int axi_len = 0;
  int csr_len = 0;

  always @(negedge mem_clk) begin
    if (mon_en) begin
      if (axi_start) axi_len++;
      if (csr_start) csr_len++;
      if (axi_grant_ack || csr_grant_ack) begin
        if (side_q.size() == 0 || len_q.size() == 0) begin
          flag("grant_unexpected");
        end else begin
          int s;
          int l;
          s = side_q.pop_front();
          l = len_q.pop_front();
          chk("grant_side", {30'd0, csr_grant_ack, axi_grant_ack}, s);
          chk("grant_owner", grant_owner, s);
          chk("start_len", (s == 1) ? axi_len : csr_len, l);
          chk("other_start", (s == 1) ? csr_len : axi_len, 0);
        end
        axi_len = 0;
        csr_len = 0;
      end
      if (xfer_timeout_err) begin
        if (end_q.size() == 0 || !end_q[0].to) begin
          flag("timeout_unexpected");
        end else begin
          chk("timeout_cyc", cyc, end_q[0].cyc_to);
          to_seen = 1'b1;
        end
      end
      if (busy_q && !arb_busy) begin
        if (end_q.size() == 0) begin
          flag("idle_unexpected");
        end else begin
          end_t e;
          e = end_q.pop_front();
          chk("idle_cyc", cyc, e.cyc_end);
          chk("idle_owner", grant_owner, 0);
          if (e.to) chk("timeout_seen", to_seen, 1);
          to_seen = 1'b0;
        end
      end
      busy_q = arb_busy;
    end
  end

  // Reference rule: single requester wins; on contention the side not
  // granted last wins, CSR first when nothing was granted yet.
  function automatic int pick(bit a, bit c, int last);
    if (a && c) return (last == 1) ? 2 : (last == 2) ? 1 : 2;
    return a ? 1 : 2;
  endfunction

  bit m_axi_p = 1'b0;
  bit m_csr_p = 1'b0;
  int m_last  = 0;
  bit abort   = 1'b0;

  initial begin
    int w, s, d, g, n, a, p, len;
    bit [1:0] r;
    axi_req = 1'b1;
    csr_req = 1'b1;
    m_axi_p = 1'b1;
    m_csr_p = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge mem_clk);
    chk("rst_busy", arb_busy, 0);
    chk("rst_owner", grant_owner, 0);
    chk("rst_axi_start", axi_start, 0);
    chk("rst_csr_start", csr_start, 0);
    chk("rst_axi_gack", axi_grant_ack, 0);
    chk("rst_csr_gack", csr_grant_ack, 0);
    chk("rst_timeout", xfer_timeout_err, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    for (int t = 0; t < 80; t++) begin
      if (t > 0) begin
        if (!m_axi_p && !m_csr_p) begin
          repeat ($urandom_range(0, 2)) @(negedge mem_clk);
          r = 2'($urandom_range(1, 3));
          if (r[0]) m_axi_p = 1'b1;
          if (r[1]) m_csr_p = 1'b1;
        end else if ($urandom_range(0, 1) == 1) begin
          m_axi_p = 1'b1;
          m_csr_p = 1'b1;
        end
        axi_req = m_axi_p;
        csr_req = m_csr_p;
      end
      w = pick(m_axi_p, m_csr_p, m_last);
      m_last = w;
      side_q.push_back(w);
      if (w == 1) m_axi_p = 1'b0;
      else m_csr_p = 1'b0;

      n = 0;
      while (!axi_start && !csr_start && n < 20) begin
        @(negedge mem_clk);
        n++;
      end
      if (!axi_start && !csr_start) begin
        flag("start_wait_expired");
        abort = 1'b1;
        break;
      end
      s = axi_start ? 1 : 2;
      d = $urandom_range(0, 3);
      len_q.push_back(d + 1);
      // A committed grant survives the requester withdrawing.
      if ($urandom_range(0, 1) == 1) begin
        axi_req = m_axi_p;
        csr_req = m_csr_p;
      end
      repeat (d) begin
        if (s == 1) csr_ack = 1'($urandom_range(0, 1));
        else axi_ack = 1'($urandom_range(0, 1));
        @(negedge mem_clk);
      end
      if (s == 1) axi_ack = 1'b1;
      else csr_ack = 1'b1;
      @(negedge mem_clk);
      axi_ack = 1'b0;
      csr_ack = 1'b0;
      axi_req = m_axi_p;
      csr_req = m_csr_p;
      a = cyc;

      g = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
      cs_gap = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) begin
        cs_gap = 5'(g);
        end_q.push_back('{1'b1, a + TO_CYC, a + TO_CYC + g + 1});
        repeat (TO_CYC) @(negedge mem_clk);
        cs_gap = 5'($urandom_range(0, 31));
      end else begin
        p   = $urandom_range(0, 4);
        len = $urandom_range(1, 6);
        repeat (p) @(negedge mem_clk);
        cs_n = 1'b0;
        repeat (len) @(negedge mem_clk);
        cs_n   = 1'b1;
        cs_gap = 5'(g);
        end_q.push_back('{1'b0, 0, cyc + g + 2});
        @(negedge mem_clk);
        cs_gap = 5'($urandom_range(0, 31));
      end

      n = 0;
      while (arb_busy && n < 80) begin
        @(negedge mem_clk);
        n++;
      end
      if (arb_busy) begin
        flag("idle_wait_expired");
        abort = 1'b1;
        break;
      end
    end

    if (!abort) begin
      mon_en = 1'b0;
      axi_req = 1'b0;
      csr_req = 1'b0;
      m_axi_p = 1'b0;
      m_csr_p = 1'b0;
      repeat (2) @(negedge mem_clk);
      csr_req = 1'b1;
      @(negedge mem_clk);
      @(negedge mem_clk);
      chk("rst_issue_start", csr_start, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_issue_start_drop", csr_start, 0);
      chk("rst_issue_busy", arb_busy, 0);
      chk("rst_issue_owner", grant_owner, 0);
      @(negedge mem_clk);
      reset_n = 1'b1;
      @(negedge mem_clk);
      chk("regrant1_start", csr_start, 1);
      chk("regrant1_owner", grant_owner, 2);
      csr_ack = 1'b1;
      @(negedge mem_clk);
      csr_ack = 1'b0;
      chk("regrant1_gack", csr_grant_ack, 1);
      cs_n = 1'b0;
      @(negedge mem_clk);
      chk("busy_before_rst", arb_busy, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_busy_busy", arb_busy, 0);
      chk("rst_busy_owner", grant_owner, 0);
      chk("rst_busy_outs",
          {27'd0, axi_start, csr_start, axi_grant_ack,
           csr_grant_ack, xfer_timeout_err}, 0);
      cs_n = 1'b1;
      @(negedge mem_clk);
      reset_n = 1'b1;
      @(negedge mem_clk);
      chk("regrant2_start", csr_start, 1);
      chk("regrant2_owner", grant_owner, 2);
      chk("regrant2_gack", csr_grant_ack, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
